// File: rtl/tcm_lsu_pkg.sv
// Shared encodings for the TCM load/store unit.
// Request sizes, one-hot TCM sizes and FSM states.
package tcm_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] MSIZE_NONE = 3'b000;
    localparam logic [2:0] MSIZE_B    = 3'b001;
    localparam logic [2:0] MSIZE_H    = 3'b010;
    localparam logic [2:0] MSIZE_W    = 3'b100;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    function automatic logic addr_err(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic e;
        e = 1'b0;
        case (size)
            SIZE_B:  e = 1'b0;
            SIZE_H:  e = off[0];
            SIZE_W:  e = (off != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/tcm_lsu_load_fmt.sv
// Load data formatter: moves the addressed lane down to bit 0
// and sign- or zero-extends it to a full word.
module tcm_lsu_load_fmt
    import tcm_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;
    logic        w_s;

    assign w_sh = i_rdata >> {i_off, 3'b000};
    assign w_s  = ~i_unsigned;

    always_comb begin
        o_data = w_sh;
        case (i_size)
            SIZE_B:  o_data = {{24{w_s & w_sh[7]}}, w_sh[7:0]};
            SIZE_H:  o_data = {{16{w_s & w_sh[15]}}, w_sh[15:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/tcm_lsu.sv
// Load/store unit between the memory stage and TCM port 1.
// One request in flight; loads take the registered TCM read word.
module tcm_lsu
    import tcm_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_size_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t r_state;
    state_t w_state_nxt;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic              r_rsp_err;
    logic              r_unsigned;
    logic [1:0]        r_off;
    logic [1:0]        r_size;

    logic              w_idle;
    logic              w_accept;
    logic              w_err;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_fmt;

    assign w_idle     = (r_state == ST_IDLE) & rst_n_i;
    assign w_accept   = w_idle & req_valid_i;
    assign w_err      = addr_err(req_size_i, req_addr_i[1:0]);
    assign w_rsp_fire = r_rsp_valid & rsp_ready_i;

    assign req_ready_o = w_idle;
    assign mem_addr_o  = req_addr_i;
    assign mem_wdata_o = req_wdata_i << {req_addr_i[1:0], 3'b000};
    assign mem_rd_o    = w_accept & ~req_we_i & ~w_err;
    assign mem_we_o    = w_accept & req_we_i & ~w_err;

    always_comb begin
        mem_size_o = MSIZE_NONE;
        case (req_size_i)
            SIZE_B:  mem_size_o = MSIZE_B;
            SIZE_H:  mem_size_o = MSIZE_H;
            SIZE_W:  mem_size_o = MSIZE_W;
            default: mem_size_o = MSIZE_NONE;
        endcase
    end

    tcm_lsu_load_fmt u_fmt (
        .i_rdata    (mem_rdata_i),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_fmt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_we_i | w_err) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_LD_WAIT;
                    end
                end
            end
            ST_LD_WAIT: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_rsp_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= ZERO_WORD;
            r_rsp_tag   <= '0;
            r_rsp_err   <= 1'b0;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_size      <= SIZE_B;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_tag  <= req_tag_i;
                r_unsigned <= req_unsigned_i;
                r_off      <= req_addr_i[1:0];
                r_size     <= req_size_i;
                if (req_we_i | w_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= ZERO_WORD;
                    r_rsp_err   <= w_err;
                end
            end
            // TCM read word is valid exactly one cycle after rd
            if (r_state == ST_LD_WAIT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_fmt;
                r_rsp_err   <= 1'b0;
            end
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_tag_o   = r_rsp_tag;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_tcm_lsu.sv
// Randomized bench for tcm_lsu against a byte-array memory model.
// Includes a small registered-read TCM model on the DUT data port.
module tb_tcm_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tcm [16];
    logic [7:0]  ref_mem [64];

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    tcm_lsu dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .req_tag_i      (req_tag),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_tag_o      (rsp_tag),
        .rsp_err_o      (rsp_err),
        .mem_addr_o     (mem_addr),
        .mem_rd_o       (mem_rd),
        .mem_we_o       (mem_we),
        .mem_size_o     (mem_size),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= tcm[mem_addr[5:2]];
        end
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                logic en;
                en = (mem_size == 3'b100) ||
                     (mem_size == 3'b010 && (l >> 1) == int'(mem_addr[1])) ||
                     (mem_size == 3'b001 && l == int'(mem_addr[1:0]));
                if (en) begin
                    tcm[mem_addr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
                end
            end
        end
    end

    task automatic check(input string tg, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tg, got, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] tg,
                         input int stall);
        logic        err;
        logic [31:0] exp;
        logic [31:0] msk;
        int          n;
        int          base;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && a[1:0] != 2'd0);
        n = 1 << sz;
        base = int'(a[5:0]);
        exp = 32'h0;
        if (!we && !err) begin
            for (int i = 0; i < n; i++) begin
                exp |= 32'(ref_mem[base + i]) << (8 * i);
            end
            if (n < 4 && !uns && exp[8*n-1]) begin
                msk = (32'h1 << (8 * n)) - 32'h1;
                exp |= ~msk;
            end
        end
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_tag      = tg;
        #1;
        check("req_ready_T", 32'(req_ready), 32'd1);
        check("mem_rd_T", 32'(mem_rd), 32'(!we && !err));
        check("mem_we_T", 32'(mem_we), 32'(we && !err));
        check("mem_addr_T", mem_addr, a);
        if (sz != 2'd3) begin
            check("mem_size_T", 32'(mem_size), 32'(1 << sz));
        end
        if (we) begin
            check("mem_wdata_T", mem_wdata, wd << (8 * int'(a[1:0])));
        end
        if (we && !err) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[base + i] = wd[8*i +: 8];
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("mem_rd_T1", 32'(mem_rd), 32'd0);
        check("mem_we_T1", 32'(mem_we), 32'd0);
        check("rsp_valid_T1", 32'(rsp_valid), 32'(we || err));
        if (!we && !err) begin
            @(negedge clk);
            #1;
            check("rsp_valid_T2", 32'(rsp_valid), 32'd1);
        end
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_rdata", rsp_rdata, exp);
            @(negedge clk);
            #1;
        end
        check("rsp_rdata", rsp_rdata, exp);
        check("rsp_tag", 32'(rsp_tag), 32'(tg));
        check("rsp_err", 32'(rsp_err), 32'(err));
        last_rdata = rsp_rdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("rsp_valid_done", 32'(rsp_valid), 32'd0);
        check("req_ready_done", 32'(req_ready), 32'd1);
    endtask

    task automatic reset_in_ldwait();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        req_tag   = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 16; i++) begin
            w = (i == 4) ? 32'h8070F0A5 : $urandom;
            tcm[i] = w;
            for (int b = 0; b < 4; b++) begin
                ref_mem[4*i + b] = w[8*b +: 8];
            end
        end
        mem_rdata    = 32'h0;
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'h0;
        req_tag      = 5'd0;
        rsp_ready    = 1'b0;
        #12;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 5'd3, 0);
        check("lb_11", last_rdata, 32'hFFFFFFF0);
        do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 5'd4, 0);
        check("lhu_12", last_rdata, 32'h00008070);
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd5, 0);
        check("lh_12", last_rdata, 32'hFFFF8070);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd6, 0);
        check("lw_10", last_rdata, 32'h8070F0A5);
        do_op(1'b1, 2'd0, 1'b0, 32'h13, 32'hAB, 5'd7, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd8, 0);
        check("lw_after_sb", last_rdata, 32'hAB70F0A5);
        do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 5'd10, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd11, 3);
        check("lw_after_sh", last_rdata, 32'h1234F0A5);
        do_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 5'd12, 0);
        do_op(1'b1, 2'd1, 1'b0, 32'h11, 32'h55AA, 5'd13, 1);
        do_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd14, 0);
        reset_in_ldwait();

        for (int k = 0; k < 300; k++) begin
            a  = 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
                a = a & ~((32'h1 << sz) - 32'h1);
            end
            do_op(1'($urandom_range(0, 1)), sz,
                  1'($urandom_range(0, 1)), a, $urandom,
                  5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tcm_lsu.md
Name: tcm_lsu

Overview:
- Load/store unit between the core's memory stage and the data port (port 1) of the tightly-coupled memory.
- Accepts one request at a time over a valid/ready handshake and checks alignment.
- Drives the TCM rd/we/size/addr/wdata signals and shifts store data onto the correct byte lanes.
- Captures the TCM's registered read word, then aligns and sign/zero-extends it before returning a tagged response over a second valid/ready handshake.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32 for byte-lane logic)
- TAG_W, 5, destination-register tag carried from request to response

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  ADDR_W  byte address
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- req_wdata_i  in  DATA_W  store data, right-justified
- req_tag_i  in  TAG_W  tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_W  formatted load data (0 for stores/errors)
- rsp_tag_o  out  TAG_W  echoed tag
- rsp_err_o  out  1  misaligned or illegal size
- mem_addr_o  out  ADDR_W  to TCM addr1
- mem_rd_o  out  1  to TCM rd1
- mem_we_o  out  1  to TCM we1
- mem_size_o  out  3  one-hot to TCM size1: 001 byte, 010 half, 100 word
- mem_wdata_o  out  DATA_W  lane-shifted store data
- mem_rdata_i  in  DATA_W  TCM data1 (registered, valid cycle after rd)

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- States: IDLE, LD_WAIT, RESP.
- Reset (async, immediate): state=IDLE; rsp_valid_o=0, rsp_rdata_o=0, rsp_tag_o=0, rsp_err_o=0. mem_rd_o and mem_we_o are 0 while rst_n_i is low.
- req_ready_o=1 only in IDLE with rst_n_i high. No request/response overlap; one request outstanding.
- err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
- Accept cycle T (IDLE, valid&ready):
  - mem_addr_o=req_addr_i always, combinational pass-through.
  - mem_size_o from req_size_i.
  - mem_wdata_o = req_wdata_i << (8*addr[1:0]), truncated to 32 bits.
  - mem_rd_o = !we & !err, combinational, this cycle only.
  - mem_we_o = we & !err, this cycle only.
  - Outside the accept cycle, mem_rd_o and mem_we_o are 0.
- Accept transitions:
  - Load, !err: latch tag, unsigned, addr[1:0], size; go to LD_WAIT.
  - Store, or err: load response registers (rdata=0, err flag, tag); go to RESP; rsp_valid_o=1 from T+1.
- LD_WAIT (T+1):
  - sh = mem_rdata_i >> (8*off).
  - byte: {24{s&sh[7]}, sh[7:0]}; half: {16{s&sh[15]}, sh[15:0]}; word: sh. Here s = !unsigned.
  - Register the result into rsp_rdata_o; go to RESP. rsp_valid_o=1 from T+2.
- RESP:
  - rsp_* held stable until rsp_valid_o&rsp_ready_i.
  - On handshake: rsp_valid_o=0, go to IDLE; a new request can be accepted the following cycle.
- Latency: load 2 cycles to rsp_valid; store/err 1 cycle. Peak throughput: one load per 3 cycles, one store per 2.
- Reset asserted in LD_WAIT or RESP: the response is dropped. A store already written in cycle T stays written.

Decomposition:
- Shared package/include holds:
  - size encodings: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10
  - one-hot TCM size constants
  - state encodings
  - ZERO_WORD
- One natural sub-module: tcm_lsu_load_fmt (combinational shift plus sign/zero-extend). The FSM, store shift and alignment check stay in the top.

Test Plan:
- Bench setup: TCM model preloaded with word 0x8070F0A5 at address 0x10.
- LB 0x11 signed -> mem_rd_o=1 in T only, mem_size_o=001; rsp_valid at T+2, rsp_rdata_o=0xFFFFFFF0, tag echoed, err=0.
- LHU 0x12 -> 0x00008070; LH 0x12 -> 0xFFFF8070; LW 0x10 -> 0x8070F0A5.
- SB wdata 0x000000AB at 0x13 -> in T: mem_we_o=1, mem_size_o=001, mem_wdata_o=0xAB000000; rsp_valid T+1 with rdata 0. Then LW 0x10 -> 0xAB70F0A5.
- SH wdata 0x1234 at 0x12 -> mem_wdata_o=0x12340000; then LW 0x10 -> 0x1234F0A5.
- LW 0x12, SH 0x11, and size=11 -> mem_rd_o=mem_we_o=0 throughout; rsp_err_o=1, rdata 0, rsp_valid at T+1.
- Backpressure and reset:
  - Hold rsp_ready_i=0 for 3 cycles after a load -> rsp_* stable and req_ready_o=0; handshake -> IDLE next cycle.
  - Assert rst_n_i low during LD_WAIT -> rsp_valid_o=0 and req_ready_o=0 immediately; after release, req_ready_o=1.
